// File: rtl/load_store_unit_if.sv
// Bundle of request/response handshakes and the data-memory port of the
// load/store unit. The master side is the processor plus the memory model;
// the slave side is the unit itself.
interface load_store_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_is_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_base;
  logic [XLEN-1:0] req_offset;
  logic [XLEN-1:0] req_store_data;
  logic [4:0]      req_rd;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;
  logic            resp_rd_we;
  logic            resp_error;

  logic [2:0]      dmem_funct3;
  logic            dmem_wren;
  logic [XLEN-1:0] dmem_address;
  logic [XLEN-1:0] dmem_data_in;
  logic [XLEN-1:0] dmem_data_out;

  modport master (
    output req_valid, req_is_store, req_funct3, req_base, req_offset,
           req_store_data, req_rd, resp_ready, dmem_data_out,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_rd_we, resp_error,
           dmem_funct3, dmem_wren, dmem_address, dmem_data_in
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_base, req_offset,
           req_store_data, req_rd, resp_ready, dmem_data_out,
    output req_ready, resp_valid, resp_data, resp_rd, resp_rd_we, resp_error,
           dmem_funct3, dmem_wren, dmem_address, dmem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine between the core FSM and the data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses return resp_error; otherwise the low address bits are cleared
// and the access proceeds.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | memory command on the bus (store write strobe or load address)
// WAIT  | counting down the memory read latency
// RESP  | response held until resp_ready
module load_store_unit #(
  parameter int unsigned MEM_READ_LATENCY = 1,
  parameter int unsigned XLEN             = 32
) (
  input logic          clk,
  input logic          reset_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [1:0]      ea_lo_q;

  logic            req_ready_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;
  logic [4:0]      resp_rd_q;
  logic            resp_rd_we_q;
  logic            resp_error_q;
  logic [2:0]      dmem_funct3_q;
  logic            dmem_wren_q;
  logic [XLEN-1:0] dmem_address_q;
  logic [XLEN-1:0] dmem_data_in_q;

  logic [XLEN-1:0] ea_d;
  logic [XLEN-1:0] ea_al_d;
  logic            illegal_d;
  logic            misalign_d;
  logic            err_d;
  logic [XLEN-1:0] load_ext_d;
  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  // Decode the incoming request: effective address, legality, alignment.
  always_comb begin
    ea_d = bus.req_base + bus.req_offset;
    if (bus.req_is_store)
      illegal_d = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      illegal_d = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign_d = ((bus.req_funct3[1:0] == 2'b01) && ea_d[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (ea_d[1:0] != 2'b00));
    ea_al_d = ea_d;
    if (bus.req_funct3[1:0] == 2'b01) ea_al_d[0]   = 1'b0;
    if (bus.req_funct3[1:0] == 2'b10) ea_al_d[1:0] = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
    err_d = illegal_d || misalign_d;
`else
    err_d = illegal_d;
`endif
  end

  // Little-endian lane select and extension of the returned word.
  always_comb begin
    byte_sh = bus.dmem_data_out >> {ea_lo_q, 3'b000};
    half_sh = bus.dmem_data_out >> {ea_lo_q[1], 4'b0000};
    case (funct3_q)
      3'b000:  load_ext_d = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_ext_d = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      3'b001:  load_ext_d = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_ext_d = {{(XLEN-16){1'b0}}, half_sh[15:0]};
      default: load_ext_d = bus.dmem_data_out;
    endcase
  end

  // Sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b010;
      ea_lo_q        <= 2'b00;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_rd_q      <= '0;
      resp_rd_we_q   <= 1'b0;
      resp_error_q   <= 1'b0;
      dmem_funct3_q  <= 3'b010;
      dmem_wren_q    <= 1'b0;
      dmem_address_q <= '0;
      dmem_data_in_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            is_store_q   <= bus.req_is_store;
            funct3_q     <= bus.req_funct3;
            ea_lo_q      <= ea_al_d[1:0];
            resp_rd_q    <= bus.req_rd;
            resp_data_q  <= '0;
            resp_rd_we_q <= 1'b0;
            req_ready_q  <= 1'b0;
            if (err_d) begin
              resp_error_q <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              resp_error_q <= 1'b0;
              state_q      <= ISSUE;
              if (bus.req_is_store) begin
                dmem_wren_q    <= 1'b1;
                dmem_funct3_q  <= bus.req_funct3;
                dmem_address_q <= ea_al_d;
                dmem_data_in_q <= bus.req_store_data;
              end else begin
                dmem_wren_q    <= 1'b0;
                dmem_funct3_q  <= 3'b010;
                dmem_address_q <= {ea_al_d[XLEN-1:2], 2'b00};
              end
            end
          end
        end
        ISSUE: begin
          if (is_store_q) begin
            dmem_wren_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q   <= 3'(MEM_READ_LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 3'd0) begin
            resp_data_q  <= load_ext_d;
            resp_rd_we_q <= (resp_rd_q != 5'd0);
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rd_we_q <= 1'b0;
            resp_error_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_rd      = resp_rd_q;
  assign bus.resp_rd_we   = resp_rd_we_q;
  assign bus.resp_error   = resp_error_q;
  assign bus.dmem_funct3  = dmem_funct3_q;
  assign bus.dmem_wren    = dmem_wren_q;
  assign bus.dmem_address = dmem_address_q;
  assign bus.dmem_data_in = dmem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance at read latency 1,
// one at read latency 3, sharing a word-addressed memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   wren_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(32)) bus0 ();
  load_store_unit_if #(.XLEN(32)) bus1 ();

  load_store_unit #(.MEM_READ_LATENCY(1), .XLEN(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  load_store_unit #(.MEM_READ_LATENCY(3), .XLEN(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] pa0;
  logic [31:0] pa1 [0:2];

  always @(posedge clk) begin
    if (bus0.dmem_wren && bus0.dmem_funct3 == 3'b010)
      mem[bus0.dmem_address[11:2]] <= bus0.dmem_data_in;
    pa0    <= bus0.dmem_address;
    pa1[0] <= bus1.dmem_address;
    pa1[1] <= pa1[0];
    pa1[2] <= pa1[1];
  end

  always @(posedge clk) if (bus0.dmem_wren) wren_cnt++;

  assign bus0.dmem_data_out = mem[pa0[11:2]];
  assign bus1.dmem_data_out = mem[pa1[2][11:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] data, input logic [4:0] rd);
    @(negedge clk);
    bus0.req_valid      = 1'b1;
    bus0.req_is_store   = st;
    bus0.req_funct3     = f3;
    bus0.req_base       = base;
    bus0.req_offset     = off;
    bus0.req_store_data = data;
    bus0.req_rd         = rd;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int edges);
    edges = 0;
    while (bus0.resp_valid !== 1'b1 && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic take;
    bus0.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus0.resp_ready = 1'b0;
    chk("take_resp_valid", bus0.resp_valid, 0);
    chk("take_req_ready", bus0.req_ready, 1);
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [4:0] rd, input logic [31:0] exp);
    int e;
    do_req(1'b0, f3, base, off, 32'h0, rd);
    wait_resp(e);
    chk({tag, "_lat"}, e, 2);
    chk({tag, "_data"}, bus0.resp_data, exp);
    chk({tag, "_err"}, bus0.resp_error, 0);
    chk({tag, "_rdwe"}, bus0.resp_rd_we, (rd != 0) ? 32'd1 : 32'd0);
    take();
  endtask

  initial begin
    int e;
    int wc;
    logic [31:0] a;
    logic seen;
    bus0.req_valid = 0; bus0.req_is_store = 0; bus0.req_funct3 = 0; bus0.req_base = 0;
    bus0.req_offset = 0; bus0.req_store_data = 0; bus0.req_rd = 0; bus0.resp_ready = 0;
    bus1.req_valid = 0; bus1.req_is_store = 0; bus1.req_funct3 = 0; bus1.req_base = 0;
    bus1.req_offset = 0; bus1.req_store_data = 0; bus1.req_rd = 0; bus1.resp_ready = 0;

    #12;
    chk("rst_req_ready", bus0.req_ready, 1);
    chk("rst_resp_valid", bus0.resp_valid, 0);
    chk("rst_wren", bus0.dmem_wren, 0);
    chk("rst_funct3", bus0.dmem_funct3, 3'b010);
    chk("rst_addr", bus0.dmem_address, 0);
    chk("rst_resp_data", bus0.resp_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // store then load
    wc = wren_cnt;
    do_req(1'b1, 3'b010, 32'h2000, 32'h4, 32'hDEADBEEF, 5'd0);
    chk("sw_wren_issue", bus0.dmem_wren, 1);
    chk("sw_addr", bus0.dmem_address, 32'h2004);
    chk("sw_wdata", bus0.dmem_data_in, 32'hDEADBEEF);
    wait_resp(e);
    chk("sw_lat", e, 1);
    chk("sw_wren_after", bus0.dmem_wren, 0);
    chk("sw_wren_cycles", wren_cnt - wc, 1);
    chk("sw_rdwe", bus0.resp_rd_we, 0);
    chk("sw_data", bus0.resp_data, 0);
    take();
    load_chk("lw", 3'b010, 32'h2000, 32'h4, 5'd5, 32'hDEADBEEF);
    chk("lw_rd", bus0.resp_rd, 5);

    // byte/half extension
    do_req(1'b1, 3'b010, 32'h1000, 32'h1000, 32'h80FF7F01, 5'd0);
    wait_resp(e);
    take();
    load_chk("lb", 3'b000, 32'h2000, 32'h3, 5'd6, 32'hFFFFFF80);
    load_chk("lbu", 3'b100, 32'h2000, 32'h3, 5'd6, 32'h00000080);
    load_chk("lh", 3'b001, 32'h2010, 32'hFFFFFFF2, 5'd6, 32'hFFFF80FF);
    load_chk("lhu", 3'b101, 32'h2000, 32'h0, 5'd6, 32'h00007F01);

    // backpressure
    do_req(1'b0, 3'b010, 32'h2004, 32'h0, 32'h0, 5'd7);
    wait_resp(e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", bus0.resp_valid, 1);
      chk("bp_data", bus0.resp_data, 32'hDEADBEEF);
      chk("bp_req_ready", bus0.req_ready, 0);
    end
    take();

    // illegal funct3 load and store
    a = bus0.dmem_address;
    wc = wren_cnt;
    do_req(1'b0, 3'b011, 32'h3000, 32'h0, 32'h0, 5'd8);
    wait_resp(e);
    chk("ill_ld_lat", e, 0);
    chk("ill_ld_err", bus0.resp_error, 1);
    chk("ill_ld_rdwe", bus0.resp_rd_we, 0);
    chk("ill_ld_addr", bus0.dmem_address, a);
    take();
    do_req(1'b1, 3'b100, 32'h3000, 32'h0, 32'h55, 5'd0);
    wait_resp(e);
    chk("ill_st_err", bus0.resp_error, 1);
    chk("ill_wren_cnt", wren_cnt - wc, 0);
    chk("ill_addr", bus0.dmem_address, a);
    take();

    // x0 destination
    load_chk("lw_x0", 3'b010, 32'h2004, 32'h0, 5'd0, 32'hDEADBEEF);

    // misaligned half
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b001, 32'h2000, 32'h1, 32'h0, 5'd9);
    wait_resp(e);
    chk("mis_lat", e, 0);
    chk("mis_err", bus0.resp_error, 1);
    chk("mis_rdwe", bus0.resp_rd_we, 0);
    take();
`else
    load_chk("mis_lh", 3'b001, 32'h2000, 32'h1, 5'd9, 32'h00007F01);
`endif

    // reset during store issue
    wc = wren_cnt;
    do_req(1'b1, 3'b010, 32'h2008, 32'h0, 32'h12345678, 5'd0);
    chk("rs_wren_issue", bus0.dmem_wren, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rs_wren_drop", bus0.dmem_wren, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus0.resp_valid !== 1'b0) seen = 1'b1;
    end
    chk("rs_no_resp", seen, 0);
    chk("rs_req_ready", bus0.req_ready, 1);
    chk("rs_no_write", wren_cnt - wc, 0);

    // latency 3 instance
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_is_store = 1'b0; bus1.req_funct3 = 3'b010;
    bus1.req_base = 32'h2000; bus1.req_offset = 32'h4; bus1.req_rd = 5'd3;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    e = 0;
    while (bus1.resp_valid !== 1'b1 && e < 50) begin
      chk("l3_addr_stable", bus1.dmem_address, 32'h2004);
      @(posedge clk);
      #1;
      e++;
    end
    chk("l3_lat", e, 4);
    chk("l3_data", bus1.resp_data, 32'hDEADBEEF);
    chk("l3_rdwe", bus1.resp_rd_we, 1);
    bus1.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.resp_ready = 1'b0;
    chk("l3_done", bus1.resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
